// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared constants and a helper for the MIPS instruction-fetch
//               stage.
//               c_instr_w   - instruction word width
//               c_nop_instr - all-zero word (sll $0,$0,0) used as a bubble
//               c_reset_pc  - default PC loaded on reset
//               align_word  - forces a byte address onto a word boundary
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int          c_instr_w   = 32;
    localparam logic [31:0] c_nop_instr = 32'h0000_0000;
    localparam logic [31:0] c_reset_pc  = 32'h0000_0000;

    // Clears the byte-offset bits of a redirect target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory read port between the fetch stage and the
//               combinational instruction ROM.
//               imem_a  - word address (fetch stage -> imem)
//               imem_rd - instruction word (imem -> fetch stage)
//               master  : fetch stage side (drives imem_a)
//               slave   : memory side (drives imem_rd)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int ADDR_W = 6
) ();

    logic [ADDR_W-1:0] imem_a;
    logic [31:0]       imem_rd;

    modport master (
        output imem_a,
        input  imem_rd
    );

    modport slave (
        input  imem_a,
        output imem_rd
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : One field of the IF/ID pipeline register.
//               clk     - rising-edge clock
//               reset   - asynchronous active-high reset, loads CLR_VAL
//               i_en    - load enable (low = hold, takes priority over clear)
//               i_clr   - synchronous clear to CLR_VAL when enabled
//               i_d     - data to capture
//               o_q     - registered field
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_en,
    input  wire logic             i_clr,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // A stalled stage keeps its contents even when a flush is requested;
    // the hazard unit re-issues the flush once the stall drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= CLR_VAL;
        end else if (i_en) begin
            r_q <= i_clr ? CLR_VAL : i_d;
        end
    end

    assign o_q = r_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage of the pipelined MIPS core. Holds the
//               PC, addresses the instruction ROM, selects the next PC
//               (pc+4 / branch / jump) and loads the IF/ID register under
//               hazard-unit stall/flush control.
// Ports       : clk, reset           - clock, async active-high reset
//               imem                 - imem read port (imem_a out, imem_rd in)
//               stall_f              - hold PC
//               stall_d / flush_d    - hold / clear IF/ID
//               pc_src_d, pc_branch_d- taken branch and its target
//               jump_d, jump_index_d - j/jal and its instr[25:0]
//               pc_f                 - current PC
//               if_id_instr/pcplus4/valid - IF/ID register contents
//               misalign_err         - sticky misaligned-redirect flag
//               fetch_cnt            - valid instructions loaded into IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int          CNT_W    = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    fetch_stage_if.master         imem,
    input  wire logic             stall_f,
    input  wire logic             stall_d,
    input  wire logic             flush_d,
    input  wire logic             pc_src_d,
    input  wire logic [31:0]      pc_branch_d,
    input  wire logic             jump_d,
    input  wire logic [25:0]      jump_index_d,
    output logic      [31:0]      pc_f,
    output logic      [c_instr_w-1:0] if_id_instr,
    output logic      [31:0]      if_id_pcplus4,
    output logic                  if_id_valid,
    output logic                  misalign_err,
    output logic      [CNT_W-1:0] fetch_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_pc;
    logic             r_misalign_err;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_jump_target;
    logic [31:0]      w_redirect_raw;
    logic             w_redirect;
    logic [31:0]      w_pc_next;
    logic             w_ifid_load_valid;

    // Word address wraps naturally by dropping the upper PC bits.
    assign imem.imem_a = r_pc[ADDR_W+1:2];

    assign w_pc_plus4    = r_pc + 32'd4;
    // The jump sits in ID, so its region bits come from its own pc+4.
    assign w_jump_target = {if_id_pcplus4[31:28], jump_index_d, 2'b00};

    // Next-PC select: stall holds and silently drops any redirect.
    always_comb begin
        w_pc_next      = w_pc_plus4;
        w_redirect     = 1'b0;
        w_redirect_raw = w_jump_target;
        if (stall_f) begin
            w_pc_next = r_pc;
        end else if (jump_d) begin
            w_redirect     = 1'b1;
            w_redirect_raw = w_jump_target;
            w_pc_next      = align_word(w_jump_target);
        end else if (pc_src_d) begin
            w_redirect     = 1'b1;
            w_redirect_raw = pc_branch_d;
            w_pc_next      = align_word(pc_branch_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_misalign_err <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_redirect && (w_redirect_raw[1:0] != 2'b00)) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

    // Counts exactly the edges on which IF/ID receives a real instruction.
    assign w_ifid_load_valid = !stall_d && !flush_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= '0;
        end else if (w_ifid_load_valid) begin
            r_fetch_cnt <= r_fetch_cnt + c_cnt_one;
        end
    end

    if_id_reg #(
        .WIDTH   (c_instr_w),
        .CLR_VAL (c_nop_instr)
    ) u_ifid_instr (
        .clk   (clk),
        .reset (reset),
        .i_en  (!stall_d),
        .i_clr (flush_d),
        .i_d   (imem.imem_rd),
        .o_q   (if_id_instr)
    );

    if_id_reg #(
        .WIDTH   (32),
        .CLR_VAL (32'h0)
    ) u_ifid_pcplus4 (
        .clk   (clk),
        .reset (reset),
        .i_en  (!stall_d),
        .i_clr (flush_d),
        .i_d   (w_pc_plus4),
        .o_q   (if_id_pcplus4)
    );

    if_id_reg #(
        .WIDTH   (1),
        .CLR_VAL (1'b0)
    ) u_ifid_valid (
        .clk   (clk),
        .reset (reset),
        .i_en  (!stall_d),
        .i_clr (flush_d),
        .i_d   (1'b1),
        .o_q   (if_id_valid)
    );

    assign pc_f         = r_pc;
    assign misalign_err = r_misalign_err;
    assign fetch_cnt    = r_fetch_cnt;

endmodule : fetch_stage
`default_nettype wire
